// File: rtl/phase_slot_scheduler_pkg.sv
// Shared definitions for the quadrature phase slot scheduler: phase count, FSM state
// codes and the per-slot phase level table.
package phase_slot_scheduler_pkg;

    localparam int unsigned NPHASE = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Each phase level is high for two consecutive slots, giving 50% duty in quadrature.
    function automatic logic [3:0] phase_pattern(input logic [1:0] slot_idx);
        logic [3:0] pat;
        case (slot_idx)
            2'd0:    pat = 4'b1001;
            2'd1:    pat = 4'b0011;
            2'd2:    pat = 4'b0110;
            default: pat = 4'b1100;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/slot_lend_arbiter.sv
// Combinational 4-way rotating-priority picker: the slot owner first, then (if lending is
// enabled) the next eligible requester in order start+1, start+2, start+3.
module slot_lend_arbiter
    import phase_slot_scheduler_pkg::*;
#(
    parameter bit WORK_CONSERVING = 1'b1
) (
    input  logic [3:0] req_i,
    input  logic [3:0] mask_i,
    input  logic [1:0] start_i,
    output logic [3:0] gnt_o
);

    logic [3:0] elig;
    logic [1:0] idx;
    logic       found;

    assign elig = req_i & mask_i;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = start_i;
        for (int i = 0; i < int'(NPHASE); i++) begin
            idx = start_i + 2'(i);
            if (!found && elig[idx] && (WORK_CONSERVING || i == 0)) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phase_slot_scheduler.sv
// Quadrature phase sequencer and time-slot arbiter: four slots per period, one grant per
// slot, with run/drain control and a config handshake open only at period boundaries.
module phase_slot_scheduler
    import phase_slot_scheduler_pkg::*;
#(
    parameter int unsigned DIV_W           = 8,
    parameter bit          WORK_CONSERVING = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [3:0]       cfg_mask,
    input  logic             run,
    input  logic [3:0]       req,
    output logic [3:0]       phase_clk,
    output logic [1:0]       slot,
    output logic [3:0]       gnt,
    output logic             period_tick,
    output logic             busy
);

    state_e           state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       mask_q, mask_d;
    logic [1:0]       slot_q, slot_d;
    logic [3:0]       phase_q;
    logic [3:0]       gnt_q;
    logic             busy_q;
    logic             slot_end;
    logic             cfg_accept;
    logic [3:0]       arb_gnt;

    assign slot_end    = (state_q != StIdle) && (cnt_q == div_q);
    assign period_tick = slot_end && (slot_q == 2'd3);
    assign cfg_ready   = (state_q == StIdle) || ((state_q == StRun) && period_tick);
    assign cfg_accept  = cfg_valid && cfg_ready;

    // An accept always precedes a slot 0, so the slot 0 grant already sees the new mask.
    assign div_d  = cfg_accept ? cfg_div : div_q;
    assign mask_d = cfg_accept ? cfg_mask : mask_q;
    assign slot_d = (state_q == StIdle) ? 2'd0 : slot_q + 2'd1;

    slot_lend_arbiter #(
        .WORK_CONSERVING(WORK_CONSERVING)
    ) u_arbiter (
        .req_i  (req),
        .mask_i (mask_d),
        .start_i(slot_d),
        .gnt_o  (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= '0;
            mask_q  <= 4'hF;
            slot_q  <= 2'd0;
            phase_q <= 4'b0000;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            mask_q <= mask_d;
            case (state_q)
                StIdle: begin
                    if (run) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        slot_q  <= slot_d;
                        phase_q <= phase_pattern(slot_d);
                        gnt_q   <= arb_gnt;
                    end
                end
                StRun, StDrain: begin
                    if ((state_q == StDrain) && !run && period_tick) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        slot_q  <= 2'd0;
                        phase_q <= 4'b0000;
                        gnt_q   <= 4'b0000;
                    end else begin
                        state_q <= run ? StRun : StDrain;
                        if (slot_end) begin
                            cnt_q   <= '0;
                            slot_q  <= slot_d;
                            phase_q <= phase_pattern(slot_d);
                            gnt_q   <= arb_gnt;
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign phase_clk = phase_q;
    assign slot      = slot_q;
    assign gnt       = gnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_phase_slot_scheduler.sv
// Vector-table bench for phase_slot_scheduler: a work-conserving and a strict instance share
// stimulus; each vector's expected outputs go through a queue and are checked after the edge.
module tb_phase_slot_scheduler;

    typedef struct {
        logic       rst_n;
        logic       run;
        logic [3:0] req;
        logic       cv;
        logic [7:0] cdiv;
        logic [3:0] cmask;
        logic [3:0] ph;
        logic [1:0] sl;
        logic [3:0] g1;
        logic [3:0] g0;
        logic       tick;
        logic       busy;
        logic       rdy;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic [3:0] cfg_mask;
    logic       run;
    logic [3:0] req;

    logic       rdy1, tick1, busy1, rdy0, tick0, busy0;
    logic [3:0] ph1, g1, ph0, g0;
    logic [1:0] sl1, sl0;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    phase_slot_scheduler #(
        .DIV_W          (8),
        .WORK_CONSERVING(1'b1)
    ) u_dut_wc (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (rdy1),
        .cfg_div    (cfg_div),
        .cfg_mask   (cfg_mask),
        .run        (run),
        .req        (req),
        .phase_clk  (ph1),
        .slot       (sl1),
        .gnt        (g1),
        .period_tick(tick1),
        .busy       (busy1)
    );

    phase_slot_scheduler #(
        .DIV_W          (8),
        .WORK_CONSERVING(1'b0)
    ) u_dut_strict (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (rdy0),
        .cfg_div    (cfg_div),
        .cfg_mask   (cfg_mask),
        .run        (run),
        .req        (req),
        .phase_clk  (ph0),
        .slot       (sl0),
        .gnt        (g0),
        .period_tick(tick0),
        .busy       (busy0)
    );

    function automatic logic [3:0] pat(input int s);
        case (s)
            0:       return 4'b1001;
            1:       return 4'b0011;
            2:       return 4'b0110;
            default: return 4'b1100;
        endcase
    endfunction

    function automatic logic [3:0] onehot(input int s);
        logic [3:0] v;
        v = 4'b0001 << s;
        return v;
    endfunction

    task automatic add_idle(input logic rst_n, input logic r, input logic [3:0] rq,
                            input logic cv, input logic [7:0] cd, input logic [3:0] cm);
        vec_t v;
        v = '{rst_n, r, rq, cv, cd, cm, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
        vecs.push_back(v);
    endtask

    task automatic add_run(input logic r, input logic [3:0] rq, input logic cv,
                           input logic [7:0] cd, input logic [3:0] cm, input int s,
                           input logic t, input logic rd, input logic [3:0] eg1,
                           input logic [3:0] eg0);
        vec_t v;
        v = '{1'b1, r, rq, cv, cd, cm, pat(s), 2'(s), eg1, eg0, t, 1'b1, rd};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s vec %0d: got %b want %b", name, idx, act, want);
    endtask

    initial begin
        logic [3:0] mg1 [4];
        logic [3:0] mg0 [4];
        vec_t v;
        int s;
        logic t;

        // Reset held with run low.
        add_idle(1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 4'h0);
        add_idle(1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 4'h0);
        // Configure div=1 while idle, then run two full periods with all requesters.
        add_idle(1'b1, 1'b0, 4'h0, 1'b1, 8'd1, 4'hF);
        for (int c = 0; c < 16; c++) begin
            s = (c / 2) % 4;
            t = (s == 3) && (c % 2 == 1);
            add_run(1'b1, 4'hF, 1'b0, 8'd0, 4'h0, s, t, t, onehot(s), onehot(s));
        end
        // div=0 accepted on the tick; only requester 2 asks: lending vs strict ownership.
        for (int c = 0; c < 8; c++) begin
            s = c % 4;
            t = (s == 3);
            add_run(1'b1, 4'b0100, c == 0, 8'd0, 4'hF, s, t, t, 4'b0100,
                    (s == 2) ? 4'b0100 : 4'b0000);
        end
        // div=1 accepted, then div=3 offered continuously: must wait for the next tick.
        for (int c = 0; c < 8; c++) begin
            s = c / 2;
            t = (c == 7);
            add_run(1'b1, 4'hF, 1'b1, (c == 0) ? 8'd1 : 8'd3, 4'hF, s, t, t, onehot(s),
                    onehot(s));
        end
        for (int c = 0; c < 16; c++) begin
            s = c / 4;
            t = (c == 15);
            add_run(1'b1, 4'hF, c == 0, 8'd3, 4'hF, s, t, t, onehot(s), onehot(s));
        end
        // run dropped in slot 1: drain to period end, ready closed, then idle.
        for (int c = 0; c < 16; c++) begin
            s = c / 4;
            t = (c == 15);
            add_run(c < 5, 4'hF, 1'b0, 8'd0, 4'h0, s, t, 1'b0, onehot(s), onehot(s));
        end
        add_idle(1'b1, 1'b0, 4'hF, 1'b0, 8'd0, 4'h0);
        add_idle(1'b1, 1'b0, 4'hF, 1'b0, 8'd0, 4'h0);
        // Restart; run briefly low in slot 1 then high again: no gap in the sequence.
        for (int c = 0; c < 16; c++) begin
            s = c / 4;
            t = (c == 15);
            add_run(!(c == 6 || c == 7), 4'hF, 1'b0, 8'd0, 4'h0, s, t, t, onehot(s),
                    onehot(s));
        end
        // Into slot 2, then reset mid-slot with run still high.
        for (int c = 0; c < 10; c++) begin
            s = c / 4;
            add_run(1'b1, 4'hF, 1'b0, 8'd0, 4'h0, s, 1'b0, 1'b0, onehot(s), onehot(s));
        end
        add_idle(1'b0, 1'b1, 4'hF, 1'b0, 8'd0, 4'h0);
        // After reset: div back to 0 and mask back to F.
        for (int c = 0; c < 4; c++) begin
            add_run(1'b1, 4'b0010, 1'b0, 8'd0, 4'h0, c, c == 3, c == 3, 4'b0010,
                    (c == 1) ? 4'b0010 : 4'b0000);
        end
        // Mask 1011 hides requester 2; lending order after the owner is k+1, k+2, k+3.
        mg1 = '{4'b0001, 4'b0010, 4'b0001, 4'b0001};
        mg0 = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
        for (int c = 0; c < 4; c++) begin
            add_run(1'b1, 4'b0111, c == 0, 8'd0, 4'b1011, c, c == 3, c == 3, mg1[c], mg0[c]);
        end

        foreach (vecs[i]) begin
            reset     = vecs[i].rst_n;
            run       = vecs[i].run;
            req       = vecs[i].req;
            cfg_valid = vecs[i].cv;
            cfg_div   = vecs[i].cdiv;
            cfg_mask  = vecs[i].cmask;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            v = exp_q.pop_front();
            chk("phase_clk", i, ph1, v.ph);
            chk("slot", i, {2'b00, sl1}, {2'b00, v.sl});
            chk("gnt_wc", i, g1, v.g1);
            chk("gnt_strict", i, g0, v.g0);
            chk("period_tick", i, {3'b000, tick1}, {3'b000, v.tick});
            chk("busy", i, {3'b000, busy1}, {3'b000, v.busy});
            chk("cfg_ready", i, {3'b000, rdy1}, {3'b000, v.rdy});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
